// File: rtl/mem_port_arbiter_pkg.sv
// Shared requester IDs and FSM state encoding for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_HOST = 2'd0;
  localparam req_id_t REQ_DMEM = 2'd1;
  localparam req_id_t REQ_IMEM = 2'd2;
  localparam req_id_t REQ_NONE = 2'd3;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOST = 1'b1
  } state_e;

endpackage

// File: rtl/mem_port_prio_sel.sv
// Combinational winner select: host > dmem > imem in RUN, host only in HOST.
// A raised starve flag lifts imem above dmem but never above the host.
module mem_port_prio_sel
  import mem_port_arbiter_pkg::*;
(
  input  state_e  state,
  input  logic    host_req,
  input  logic    dmem_req,
  input  logic    imem_req,
  input  logic    starve,
  output req_id_t winner
);

  always_comb begin
    winner = REQ_NONE;
    if (host_req) begin
      winner = REQ_HOST;
    end else if (state == ST_RUN) begin
      if (imem_req && starve) begin
        winner = REQ_IMEM;
      end else if (dmem_req) begin
        winner = REQ_DMEM;
      end else if (imem_req) begin
        winner = REQ_IMEM;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port data memory arbiter (host/dmem/imem): same-cycle grant, read data one cycle later.
// Losers see stall_o until granted; host lock excludes the pipeline. ARB_STARVE_GUARD_EN adds fetch anti-starvation.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD       = 32,
  parameter int ADDR       = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            host_req,
  input  logic            host_we,
  input  logic            host_lock,
  input  logic [ADDR-1:0] host_addr,
  input  logic [WORD-1:0] host_wdata,
  output logic            host_gnt,
  output logic            host_rvalid,
  input  logic            dmem_req,
  input  logic            dmem_we,
  input  logic [ADDR-1:0] dmem_addr,
  input  logic [WORD-1:0] dmem_wdata,
  output logic            dmem_gnt,
  output logic            dmem_rvalid,
  input  logic            imem_req,
  input  logic [ADDR-1:0] imem_addr,
  output logic            imem_gnt,
  output logic            imem_rvalid,
  output logic [WORD-1:0] rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            stall_o,
  output logic            locked
);

  if (STARVE_MAX < 1) begin : g_starve_max_check
    $error("STARVE_MAX must be at least 1");
  end

  state_e  state, state_nxt;
  req_id_t winner;
  logic    starve;

  mem_port_prio_sel u_prio_sel (
    .state    (state),
    .host_req (host_req),
    .dmem_req (dmem_req),
    .imem_req (imem_req),
    .starve   (starve),
    .winner   (winner)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Grants are computed first because the lock transition depends on host_gnt.
  always_comb begin
    host_gnt  = 1'b0;
    dmem_gnt  = 1'b0;
    imem_gnt  = 1'b0;
    state_nxt = state;
    if (reset) begin
      host_gnt = (winner == REQ_HOST);
      dmem_gnt = (winner == REQ_DMEM);
      imem_gnt = (winner == REQ_IMEM);
    end
    case (state)
      ST_RUN:  if (host_gnt && host_lock) state_nxt = ST_HOST;
      ST_HOST: if (!host_lock) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (dmem_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dmem_we;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end else if (imem_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      host_rvalid <= 1'b0;
      dmem_rvalid <= 1'b0;
      imem_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      dmem_rvalid <= dmem_gnt & ~dmem_we;
      imem_rvalid <= imem_gnt;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_CW = $clog2(STARVE_MAX + 1);
  logic [STARVE_CW-1:0] starve_cnt;

  // Saturates at STARVE_MAX; host-lock cycles hold the count rather than add to it.
  always_ff @(posedge clk) begin
    if (!reset || !imem_req || imem_gnt) begin
      starve_cnt <= '0;
    end else if (state == ST_RUN && starve_cnt != STARVE_CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + STARVE_CW'(1);
    end
  end

  assign starve = (state == ST_RUN) && (starve_cnt == STARVE_CW'(STARVE_MAX));
`else
  assign starve = 1'b0;
`endif

  assign rdata   = (host_rvalid | dmem_rvalid | imem_rvalid) ? mem_rdata : '0;
  assign locked  = (state == ST_HOST);
  assign stall_o = ~reset | (dmem_req & ~dmem_gnt) | (imem_req & ~imem_gnt) | locked;

endmodule
